// File: rtl/seq_divider_signed.sv
// Purpose : sequential signed divider, 16-bit dividend by 8-bit divisor, 8-bit quotient/remainder.
// Latency : 17 cycles from the start edge to done (1 cycle when the divisor is zero).
// Backpr. : start is accepted only while idle; busy=1 means start and operands are ignored.
// Option  : define DIV_OVF_DETECT_EN to saturate out-of-range quotients and raise ovf.
module seq_divider_signed (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic [7:0]  quotient,
    output logic [7:0]  remainder,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic        ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Operand / working registers. dq starts as the dividend magnitude and is
    // shifted left each step, with quotient bits entering at the LSB; after 16
    // steps it holds the quotient magnitude. For a zero divisor it keeps the
    // raw dividend so its low byte can be returned as the remainder.
    logic        dvd_neg;
    logic        dvs_neg;
    logic        dz_pend;
    logic [15:0] dq;
    logic [7:0]  dvs_mag;
    logic [7:0]  prem;
    logic [3:0]  cnt;

    // Start-edge decode.
    logic        accept;
    logic        dvs_zero;
    logic [15:0] dvd_abs;
    logic [7:0]  dvs_abs;

    // One restoring step: 9-bit trial remainder, borrow decides the quotient bit.
    logic [8:0]  trial;
    logic [8:0]  diff;
    logic        q_bit;
    logic [7:0]  prem_nxt;
    logic [15:0] dq_nxt;

    // Sign fix-up of the final magnitudes.
    logic        q_neg;
    logic [7:0]  q_lo;
    logic [7:0]  r_signed;
    logic [7:0]  q_fin;
    logic        ovf_fin;

    // Operand magnitudes and start acceptance.
    always_comb begin
        accept   = (state == IDLE) && start;
        dvs_zero = (divisor == 8'd0);
        dvd_abs  = dividend[15] ? (~dividend + 16'd1) : dividend;
        dvs_abs  = divisor[7]   ? (~divisor  + 8'd1)  : divisor;
    end

    // Restoring shift-subtract step, MSB of the dividend first.
    always_comb begin
        trial    = {prem, dq[15]};
        diff     = trial - {1'b0, dvs_mag};
        q_bit    = ~diff[8];
        prem_nxt = q_bit ? diff[7:0] : trial[7:0];
        dq_nxt   = {dq[14:0], q_bit};
    end

    // Apply signs (truncation toward zero) and range handling of the quotient.
    // Negating only the low byte is enough for the wrapped result, since the
    // low bits of -x depend only on the low bits of x.
    always_comb begin
        q_neg    = (dvd_neg ^ dvs_neg) && (dq != 16'd0);
        q_lo     = q_neg ? (~dq[7:0] + 8'd1) : dq[7:0];
        r_signed = dvd_neg ? (~prem + 8'd1) : prem;
`ifdef DIV_OVF_DETECT_EN
        ovf_fin  = q_neg ? (dq > 16'd128) : (dq > 16'd127);
        if (ovf_fin) begin
            q_fin = q_neg ? 8'h80 : 8'h7F;
        end else begin
            q_fin = q_lo;
        end
`else
        ovf_fin  = 1'b0;
        q_fin    = q_lo;
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a zero divisor goes straight to SIGN.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = dvs_zero ? SIGN : CALC;
                end
            end
            CALC: begin
                if (cnt == 4'd15) begin
                    state_nxt = SIGN;
                end
            end
            SIGN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture on accept, one division step per CALC cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_neg <= 1'b0;
            dvs_neg <= 1'b0;
            dz_pend <= 1'b0;
            dq      <= 16'd0;
            dvs_mag <= 8'd0;
            prem    <= 8'd0;
            cnt     <= 4'd0;
        end else if (accept) begin
            dvd_neg <= dividend[15];
            dvs_neg <= divisor[7];
            dz_pend <= dvs_zero;
            dq      <= dvs_zero ? dividend : dvd_abs;
            dvs_mag <= dvs_abs;
            prem    <= 8'd0;
            cnt     <= 4'd0;
        end else if (state == CALC) begin
            dq      <= dq_nxt;
            prem    <= prem_nxt;
            cnt     <= cnt + 4'd1;
        end
    end

    // Result registers; they only change on the edge that raises done.
    always_ff @(posedge clk) begin
        if (rst) begin
            quotient    <= 8'd0;
            remainder   <= 8'd0;
            div_by_zero <= 1'b0;
            ovf         <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == SIGN) begin
                done <= 1'b1;
                if (dz_pend) begin
                    quotient    <= dvd_neg ? 8'h80 : 8'h7F;
                    remainder   <= dq[7:0];
                    div_by_zero <= 1'b1;
                    ovf         <= 1'b0;
                end else begin
                    quotient    <= q_fin;
                    remainder   <= r_signed;
                    div_by_zero <= 1'b0;
                    ovf         <= ovf_fin;
                end
            end
        end
    end

    // busy covers the iterative path only; the zero-divisor shortcut never shows busy.
    always_comb begin
        busy = (state == CALC) || ((state == SIGN) && !dz_pend);
    end

endmodule

// File: tb/tb_seq_divider_signed.sv
// Purpose : scoreboard bench for seq_divider_signed against a behavioural signed-division model.
// Latency : expects done 17 edges after an accepted start (1 for a zero divisor).
// Backpr. : starts issued while busy are expected to be ignored.
module tb_seq_divider_signed;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic        ovf;

    seq_divider_signed dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ov;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    int ta [10] = '{100, -100, 100, -128, 1000, -32768, -32768, -32768, 127, -1};
    int tv [10] = '{7,   7,    -7,  1,    2,    -1,     1,      -128,   -128, 3};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: SV integer division truncates toward zero, % takes the dividend sign.
    function automatic exp_t model(input int a, input int b, input int due);
        exp_t e;
        int   qi;
        int   ri;
        e.due = due;
        if (b == 0) begin
            e.q  = (a >= 0) ? 8'h7F : 8'h80;
            e.r  = a[7:0];
            e.dz = 1'b1;
            e.ov = 1'b0;
        end else begin
            qi   = a / b;
            ri   = a % b;
            e.r  = ri[7:0];
            e.dz = 1'b0;
`ifdef DIV_OVF_DETECT_EN
            if (qi > 127) begin
                e.q = 8'h7F; e.ov = 1'b1;
            end else if (qi < -128) begin
                e.q = 8'h80; e.ov = 1'b1;
            end else begin
                e.q = qi[7:0]; e.ov = 1'b0;
            end
`else
            e.q  = qi[7:0];
            e.ov = 1'b0;
`endif
        end
        return e;
    endfunction

    // Called at a negedge; start is sampled at the next posedge (cycle cyc+1).
    task automatic issue(input logic [15:0] a, input logic [7:0] b, input bit accept);
        int n;
        n        = cyc + 1;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        if (accept) sb.push_back(model($signed(a), $signed(b), n + ((b == 8'd0) ? 1 : 17)));
        @(negedge clk);
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    // Result monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("latency", cyc, e.due);
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                check("div_by_zero", div_by_zero, e.dz);
                check("ovf", ovf, e.ov);
                check("busy_in_done", busy, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 16'd0;
        divisor  = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dz", div_by_zero, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic case with busy observed mid-operation.
        issue(16'd100, 8'd7, 1'b1);
        check("busy_run", busy, 1);
        wait_drain();

        // Signed and boundary vectors.
        for (int i = 0; i < 10; i++) begin
            issue(16'(ta[i]), 8'(tv[i]), 1'b1);
            wait_drain();
        end

        // Zero divisor: busy must stay low through to done.
        issue(16'd50, 8'd0, 1'b1);
        check("dz_busy0", busy, 0);
        @(negedge clk);
        check("dz_busy1", busy, 0);
        wait_drain();
        issue(16'hFF9C, 8'd0, 1'b1);
        wait_drain();

        // Second start at N+5 ignored; start in the done cycle accepted.
        issue(16'd1234, 8'hFB, 1'b1);
        repeat (4) @(negedge clk);
        issue(16'd77, 8'd3, 1'b0);
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", done, 1);
        issue(16'hF000, 8'd9, 1'b1);
        wait_drain();

        // Reset mid-operation at edge N+8 aborts with no done.
        issue(16'd300, 8'd9, 1'b1);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        sb.delete();
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_dz", div_by_zero, 0);
        check("abort_ovf", ovf, 0);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        issue(16'hFED4, 8'd9, 1'b1);
        wait_drain();

        // Random operands.
        for (int i = 0; i < 8; i++) begin
            issue(16'($urandom), 8'($urandom), 1'b1);
            wait_drain();
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_divider_signed.md
SEQ_DIVIDER_SIGNED -- requirements
Module: seq_divider_signed

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset, sampled on the clk rising edge.
REQ-003 SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-004 SHALL have port dividend, input, 16 bits: two's-complement dividend.
REQ-005 SHALL have port divisor, input, 8 bits: two's-complement divisor.
REQ-006 SHALL have port quotient, output, 8 bits: two's-complement quotient, registered.
REQ-007 SHALL have port remainder, output, 8 bits: two's-complement remainder, registered.
REQ-008 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when quotient and remainder are valid.
REQ-010 SHALL have port div_by_zero, output, 1 bit: result flag, valid with done.
REQ-011 SHALL have port ovf, output, 1 bit: quotient-overflow flag, valid with done.

Function
REQ-012 SHALL implement states IDLE, CALC and SIGN.
- IDLE -> CALC on an edge with start=1 and divisor!=0.
- CALC -> SIGN after exactly 16 iterations.
- SIGN -> IDLE on the next edge.
REQ-013 On the start edge, SHALL register dividend and divisor sign bits, register operand magnitudes (|dividend| 16-bit unsigned, so -32768 gives 0x8000; |divisor| 8-bit unsigned, so -128 gives 0x80), and clear the iteration counter.
REQ-014 In CALC, SHALL perform one restoring shift-subtract step per cycle, MSB first, using a 9-bit partial remainder, producing a 16-bit quotient magnitude and an 8-bit remainder magnitude.
REQ-015 SHALL truncate toward zero.
- Quotient is negative iff the operand signs differ and the magnitude is nonzero.
- Remainder takes the dividend's sign.
- Identity dividend = q*divisor + r SHALL hold whenever ovf=0.
REQ-016 If start is sampled at edge N with divisor!=0, SHALL update quotient, remainder and flags and assert done for the cycle following edge N+17 (latency 17 cycles).
REQ-017 busy SHALL be high from the cycle after edge N until done is high.
- busy SHALL be low during the done cycle.
- A start in the done cycle SHALL be accepted.
REQ-018 start SHALL be ignored while busy=1, and operand changes while busy SHALL NOT affect the running operation.
REQ-019 If divisor==0 on the start edge, SHALL skip CALC and assert done after the next edge (latency 1), with:
- div_by_zero=1, ovf=0;
- quotient=0x7F if dividend>=0, else 0x80;
- remainder=dividend[7:0].
REQ-020 quotient, remainder, div_by_zero and ovf SHALL hold their values until the next done.
REQ-021 Exact signed result -128 SHALL be reported as 0x80 with ovf=0.

Reset
REQ-022 While rst=1, SHALL hold state=IDLE with quotient=0, remainder=0, busy=0, done=0, div_by_zero=0 and ovf=0.
REQ-023 rst asserted mid-operation SHALL abort the operation, and done SHALL NOT pulse for the aborted operation.
REQ-024 rst SHALL take priority over start on the same edge.

Configuration
REQ-025 With macro DIV_OVF_DETECT_EN defined, when the signed quotient falls outside -128..127, SHALL saturate quotient to 0x7F (positive) or 0x80 (negative), set ovf=1, and report the remainder unchanged.
REQ-026 Without DIV_OVF_DETECT_EN, SHALL output quotient = low 8 bits of the two's-complement 16-bit true quotient, and ovf SHALL be tied 0.

Verification
REQ-027 SHALL verify dividend=100, divisor=7, start at edge N -> done at N+17, quotient=0x0E, remainder=0x02, ovf=0, div_by_zero=0.
REQ-028 SHALL verify signed results:
- dividend=-100, divisor=7 -> quotient=0xF2, remainder=0xFE.
- dividend=100, divisor=-7 -> quotient=0xF2, remainder=0x02.
- dividend=-128, divisor=1 -> quotient=0x80, ovf=0.
REQ-029 SHALL verify dividend=50, divisor=0 -> done one cycle later, div_by_zero=1, quotient=0x7F, remainder=0x32, busy never high.
REQ-030 SHALL verify dividend=1000, divisor=2:
- with DIV_OVF_DETECT_EN -> quotient=0x7F, ovf=1, remainder=0;
- without it -> quotient=0xF4, ovf=0.
REQ-031 SHALL verify a second start pulse at edge N+5 -> ignored, a single done at N+17; a start in the done cycle -> accepted, next done 17 cycles later.
REQ-032 SHALL verify rst=1 at edge N+8 -> no done, all outputs 0, busy=0; then a new start completes normally with correct results.
